// File: rtl/rca_16bit_pkg.sv
// Shared constants for the ripple-carry adder slice.
package rca_16bit_pkg;

  // Default operand and sum width of the adder.
  localparam int RCA_WIDTH = 16;

endpackage

// File: rtl/rca_full_adder.sv
// One-bit full adder: the single stage that the ripple chain is built from.
module rca_full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ cin;
  assign co = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/rca_16bit.sv
// Unsigned ripple-carry adder with a registered result.
// A chain of WIDTH full adders computes {cout,sum} = a + b combinationally;
// the result is captured one cycle later, qualified by out_valid.
module rca_16bit
  import rca_16bit_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Stage p0: combinational ripple chain, no carry-in.
  logic [WIDTH:0]   carry_p0;
  logic [WIDTH-1:0] s_p0;

  assign carry_p0[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    rca_full_adder u_fa (
      .x   (a[i]),
      .y   (b[i]),
      .cin (carry_p0[i]),
      .s   (s_p0[i]),
      .co  (carry_p0[i+1])
    );
  end

  // Stage p1: output register.
  logic             vld_p1;
  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1;

  // Capture the chain result on valid input; reset clears the result and
  // drops the valid immediately, discarding anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1  <= s_p0;
        cout_p1 <= carry_p0[WIDTH];
      end
    end
  end

  assign out_valid = vld_p1;
  assign sum       = sum_p1;
  assign cout      = cout_p1;

endmodule

// File: tb/tb_rca_16bit.sv
// Self-checking bench for rca_16bit: directed boundary vectors, hold and
// back-to-back behaviour, asynchronous reset, and randomized operands
// compared against a 17-bit arithmetic reference.
module tb_rca_16bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [15:0] sum;
  logic        cout;

  int checks   = 0;
  int failures = 0;

  // Reference state: last captured 17-bit result and the expected valid.
  logic [16:0] mdl_res;
  logic        mdl_vld;

  rca_16bit #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then check outputs just after the edge.
  task automatic step(input logic v, input logic [15:0] xa, input logic [15:0] xb);
    @(negedge clk);
    in_valid = v;
    a        = xa;
    b        = xb;
    @(posedge clk);
    #1;
    mdl_vld = v;
    if (v) mdl_res = {1'b0, xa} + {1'b0, xb};
    chk("out_valid", {31'b0, out_valid}, {31'b0, mdl_vld});
    chk("sum",       {16'b0, sum},       {16'b0, mdl_res[15:0]});
    chk("cout",      {31'b0, cout},      {31'b0, mdl_res[16]});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sum"},  {16'b0, sum},       32'h0);
    chk({tag, "_cout"}, {31'b0, cout},      32'h0);
    chk({tag, "_vld"},  {31'b0, out_valid}, 32'h0);
  endtask

  initial begin
    logic [15:0] held_sum;
    logic        held_cout;

    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    mdl_res  = '0;
    mdl_vld  = 1'b0;

    // Power-on reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1 chk_zero("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    step(1'b1, 16'h1234, 16'h4321);
    chk("basic_sum", {16'b0, sum}, 32'h5555);
    chk("basic_cout", {31'b0, cout}, 32'h0);
    step(1'b1, 16'hFFFF, 16'h0001);
    chk("ripple_sum", {16'b0, sum}, 32'h0000);
    chk("ripple_cout", {31'b0, cout}, 32'h1);
    step(1'b1, 16'h8000, 16'h8000);
    chk("msb_sum", {16'b0, sum}, 32'h0000);
    chk("msb_cout", {31'b0, cout}, 32'h1);
    step(1'b1, 16'hFFFF, 16'hFFFF);
    chk("max_sum", {16'b0, sum}, 32'hFFFE);
    chk("max_cout", {31'b0, cout}, 32'h1);
    step(1'b1, 16'h0000, 16'h0000);
    chk("zero_sum", {16'b0, sum}, 32'h0000);
    chk("zero_cout", {31'b0, cout}, 32'h0);

    // Back-to-back valid pairs, then idle cycles with changing operands.
    step(1'b1, 16'h0F0F, 16'h00F1);
    step(1'b1, 16'hA5A5, 16'h5A5B);
    step(1'b1, 16'h7FFF, 16'h0003);
    chk("b2b_sum", {16'b0, sum}, 32'h8002);
    held_sum  = sum;
    held_cout = cout;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'($urandom), 16'($urandom));
      chk("hold_sum", {16'b0, sum}, {16'b0, held_sum});
      chk("hold_cout", {31'b0, cout}, {31'b0, held_cout});
    end

    // Asynchronous reset mid-cycle with a non-zero result present.
    step(1'b1, 16'h1234, 16'h0000);
    chk("pre_rst_sum", {16'b0, sum}, 32'h1234);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    in_valid = 1'b1;
    a        = 16'h1111;
    b        = 16'h2222;
    @(posedge clk);
    #1 chk_zero("rst_held");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    mdl_res  = '0;
    mdl_vld  = 1'b0;

    // Randomized operands with random valid.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    end

    // Reset while a valid pair is in flight discards it.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 16'hBEEF;
    b        = 16'h1001;
    #3 rst_n = 1'b0;
    #1 chk_zero("inflight_rst");
    @(posedge clk);
    #1 chk_zero("inflight_edge");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    mdl_res  = '0;
    mdl_vld  = 1'b0;
    step(1'b0, 16'h0001, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
